// File: rtl/eaglesong_nonce_search.sv
// Nonce search controller for one Eaglesong digest core: launches {nonce, header} evaluations until hit, exhaustion or abort.
// Optional WAIT/DRAIN watchdog is built when EAGLESONG_SEARCH_TIMEOUT_EN is defined.
module eaglesong_nonce_search #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [223:0] header,
   input  logic [31:0]  nonce_start,
   input  logic [31:0]  max_iters,
   input  logic [255:0] target,
   output logic [255:0] dig_input_val,
   output logic [6:0]   dig_input_length_bytes,
   output logic         dig_start_eval,
   input  logic [255:0] dig_output_val,
   input  logic         dig_eval_output_ready,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic [31:0]  found_nonce,
   output logic [255:0] found_digest,
   output logic [31:0]  iter_count,
   output logic         timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_CHECK  = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   state_t state, state_next;

   logic [31:0]  max_iters_q, max_iters_d;
   logic [255:0] target_q, target_d;
   logic [255:0] digest_q, digest_d;
   logic [255:0] input_val_d;
   logic [255:0] found_digest_d;
   logic [31:0]  found_nonce_d, iter_count_d, iter_inc_c;
   logic         busy_d, done_d, found_d, start_eval_d, timeout_err_d;
   logic         hit_c, exhausted_c, timeout_c;

   assign dig_input_length_bytes = 7'd32;
   assign iter_inc_c  = iter_count + 32'd1;
   assign hit_c       = (digest_q <= target_q);
   assign exhausted_c = (max_iters_q != 32'd0) && (iter_inc_c == max_iters_q);

`ifdef EAGLESONG_SEARCH_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] to_cnt;

   // Watchdog restarts on every entry into WAIT or DRAIN
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if ((state_next == S_WAIT || state_next == S_DRAIN) && state_next != state) begin
         to_cnt <= '0;
      end else if (state == S_WAIT || state == S_DRAIN) begin
         to_cnt <= to_cnt + CNT_W'(1);
      end
   end

   assign timeout_c = !dig_eval_output_ready && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Abort outranks hit, hit outranks exhaustion
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_LAUNCH;
         S_LAUNCH: state_next = abort ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (abort)                      state_next = dig_eval_output_ready ? S_IDLE : S_DRAIN;
            else if (dig_eval_output_ready) state_next = S_CHECK;
            else if (timeout_c)             state_next = S_IDLE;
         end
         S_CHECK: begin
            if (abort || hit_c || exhausted_c) state_next = S_IDLE;
            else                               state_next = S_LAUNCH;
         end
         S_DRAIN:  if (dig_eval_output_ready || timeout_c) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d         = (state_next != S_IDLE);
      done_d         = (state != S_IDLE) && (state_next == S_IDLE);
      start_eval_d   = (state_next == S_LAUNCH);
      input_val_d    = dig_input_val;
      max_iters_d    = max_iters_q;
      target_d       = target_q;
      digest_d       = digest_q;
      found_d        = found;
      found_nonce_d  = found_nonce;
      found_digest_d = found_digest;
      iter_count_d   = iter_count;
      timeout_err_d  = timeout_err;
      case (state)
         S_IDLE: begin
            if (start) begin
               input_val_d   = {nonce_start, header};
               max_iters_d   = max_iters;
               target_d      = target;
               iter_count_d  = 32'd0;
               found_d       = 1'b0;
               timeout_err_d = 1'b0;
            end
         end
         S_WAIT: if (dig_eval_output_ready) digest_d = dig_output_val;
         S_CHECK: begin
            if (!abort) begin
               iter_count_d = iter_inc_c;
               if (hit_c) begin
                  found_d        = 1'b1;
                  found_nonce_d  = dig_input_val[255:224];
                  found_digest_d = digest_q;
               end else if (!exhausted_c) begin
                  input_val_d[255:224] = dig_input_val[255:224] + 32'd1;
               end
            end
         end
         default: ;
      endcase
      if ((state == S_WAIT || state == S_DRAIN) && state_next == S_IDLE && timeout_c)
         timeout_err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         dig_start_eval <= 1'b0;
         dig_input_val  <= '0;
         max_iters_q    <= '0;
         target_q       <= '0;
         digest_q       <= '0;
         found          <= 1'b0;
         found_nonce    <= '0;
         found_digest   <= '0;
         iter_count     <= '0;
         timeout_err    <= 1'b0;
      end else begin
         busy           <= busy_d;
         done           <= done_d;
         dig_start_eval <= start_eval_d;
         dig_input_val  <= input_val_d;
         max_iters_q    <= max_iters_d;
         target_q       <= target_d;
         digest_q       <= digest_d;
         found          <= found_d;
         found_nonce    <= found_nonce_d;
         found_digest   <= found_digest_d;
         iter_count     <= iter_count_d;
         timeout_err    <= timeout_err_d;
      end
   end

endmodule
